ex_muldiv: RTL and testbench
============================

Name:
ex_muldiv

Overview:
Parametrised iterative multiply/divide unit with architectural HI/LO registers, sitting beside the EX-stage ALU of the MIPS pipeline. It accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO from EX, runs multi-cycle operations with a busy/done handshake the pipeline uses to stall MFHI/MFLO, and exposes HI/LO for MFHI/MFLO.

Parameters:
XLEN, 32, operand width; HI/LO are XLEN each. Legal values: 8..64.
CNT_W, $clog2(XLEN)+1, iteration counter width (derived, not overridden).

Ports:
CLK  in  1  clock; all state updates on posedge.
RST  in  1  synchronous active-high reset.
start  in  1  op request; sampled only in IDLE.
op  in  3  operation code (muldiv_pkg): 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved.
rs_val  in  XLEN  multiplicand/dividend; MTHI/MTLO source.
rt_val  in  XLEN  multiplier/divisor.
busy  out  1  high while a multi-cycle op is in flight.
done  out  1  one-cycle pulse when HI/LO hold a new mult/div result.
div_by_zero  out  1  valid with done; set when the op was DIV/DIVU with rt_val==0.
hi  out  XLEN  HI register.
lo  out  XLEN  LO register.

Behaviour:
- Reset (sync, RST=1 at posedge): state=IDLE; hi=lo=0; busy=done=div_by_zero=0; counter=0. Reset mid-operation aborts the op and leaves no partial result.
- States: IDLE -> RUN -> FIX -> IDLE.
- IDLE: start=1 with op 1..4 latches operands, operand signs and op kind; magnitudes are taken for signed ops; state=RUN; counter=XLEN. start with op 5/6 writes hi/lo from rs_val at that edge, stays IDLE, and does not pulse done. op 0/7 is ignored.
- RUN: busy=1. One radix-2 step per cycle. Multiply uses shift-add on a 2*XLEN accumulator. Divide uses restoring shift-subtract producing quotient and remainder. Counter decrements each cycle; RUN->FIX when the counter reaches 1.
- FIX: busy=1. Sign correction for signed ops. Product is negated when the operand signs differ. Quotient is negated when the signs differ. Remainder takes the dividend's sign. At the FIX edge, hi/lo are written: mult gives {hi,lo}=product; div gives lo=quotient, hi=remainder. State returns to IDLE.
- done=1 and busy=0 in the first IDLE cycle after FIX; done clears the cycle after. A new start is accepted in that same cycle.
- Latency: start accepted at edge 0; busy high for cycles 1..XLEN+1; done in cycle XLEN+2.
- start while busy is ignored: no queueing and no operand capture.
- Divide by zero takes the same latency. Result: lo=all ones, hi=rs_val (the original signed value), div_by_zero=1.
- Signed overflow case (DIV, most-negative / -1): lo=most-negative, hi=0. No flag.
- hi/lo are stable during RUN/FIX; they always show the last committed values.

Optional Feature:
MULDIV_FAST_MUL_EN.
- Defined: MULT/MULTU use a single-cycle full XLEN x XLEN multiplier. hi/lo are written at the accept edge; busy is never asserted; done=1 in the next cycle. DIV/DIVU are unchanged.
- Undefined: all mult/div ops use the iterative path, with latency XLEN+2.

Decomposition:
- muldiv_pkg holds the op code constants, state encoding, and a localparam for the reserved op code.
- One sub-module, muldiv_step, is natural: a combinational single-iteration datapath (add/shift for multiply, subtract/restore for divide) instanced by the RUN state.
- The sign handling and the FSM stay in ex_muldiv.

Test Plan:
- MULTU rs=0xFFFFFFFF, rt=2 -> hi=0x00000001, lo=0xFFFFFFFE; busy high cycles 1..33; done in cycle 34.
- MULT rs=0xFFFFFFFD (-3), rt=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; done=1 exactly one cycle.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU rs=100, rt=0 -> lo=0xFFFFFFFF, hi=0x00000064, div_by_zero=1.
- MTHI rs=0x12345678, then MTLO rs=0xCAFEBABE on consecutive cycles in IDLE -> hi/lo updated one edge each; done stays 0.
- MULTU started, second start (DIVU) at cycle 5 -> ignored, first result intact. RST at cycle 10 of a DIV -> hi=lo=0, busy=0, no done.
- With MULDIV_FAST_MUL_EN: MULT 7 x -2 -> lo=0xFFFFFFF2, hi=0xFFFFFFFF, done in cycle 1, busy never 1.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op codes and FSM state encoding.
package muldiv_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_NOP   = 3'd0;
    localparam op_t OP_MULT  = 3'd1;
    localparam op_t OP_MULTU = 3'd2;
    localparam op_t OP_DIV   = 3'd3;
    localparam op_t OP_DIVU  = 3'd4;
    localparam op_t OP_MTHI  = 3'd5;
    localparam op_t OP_MTLO  = 3'd6;
    localparam op_t OP_RSVD  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

endpackage

// File: rtl/ex_muldiv_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
interface ex_muldiv_if #(
    parameter int XLEN = 32
);
    import muldiv_pkg::*;

    // start is only honoured while busy=0; busy covers the whole iterative op,
    // done is a single-cycle pulse once HI/LO hold the new result.
    logic            start;
    op_t             op;
    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;
    logic            busy;
    logic            done;
    logic            div_by_zero;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    state_e          dbg_state;

    modport master (
        output start, op, rs_val, rt_val,
        input  busy, done, div_by_zero, hi, lo, dbg_state
    );

    modport slave (
        input  start, op, rs_val, rt_val,
        output busy, done, div_by_zero, hi, lo, dbg_state
    );

endinterface

// File: rtl/ex_muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic              is_div_i,
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [XLEN-1:0]   opb_i,
    output logic [2*XLEN-1:0] acc_o
);

    logic [XLEN:0] sum;
    logic [XLEN:0] rem;
    logic [XLEN:0] diff;

    always_comb begin
        sum  = {1'b0, acc_i[2*XLEN-1:XLEN]} + {1'b0, (acc_i[0] ? opb_i : {XLEN{1'b0}})};
        // Upper half after the left shift; one extra bit keeps the carried-out MSB.
        rem  = acc_i[2*XLEN-1:XLEN-1];
        diff = rem - {1'b0, opb_i};
        if (is_div_i) begin
            if (!diff[XLEN]) begin
                acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
            end else begin
                acc_o = {rem[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_o = {sum, acc_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative MIPS multiply/divide unit with HI/LO. Define MULDIV_FAST_MUL_EN for a
// single-cycle MULT/MULTU path; DIV/DIVU always iterate.
module ex_muldiv
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic        CLK,
    input  logic        RST,
    ex_muldiv_if.slave  bus
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d, acc_step;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [XLEN-1:0]   rs_q, rs_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              is_div_q, is_div_d;
    logic              sign_a_q, sign_a_d;
    logic              sign_b_q, sign_b_d;
    logic              done_q, done_d;
    logic              dbz_q, dbz_d;

    logic              is_muldiv_op;
    logic              is_div_op;
    logic              signed_op;
    logic              sa, sb;
    logic [XLEN-1:0]   rs_mag, rt_mag;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;

    always_comb begin
        fast_a    = {{XLEN{signed_op & bus.rs_val[XLEN-1]}}, bus.rs_val};
        fast_b    = {{XLEN{signed_op & bus.rt_val[XLEN-1]}}, bus.rt_val};
        fast_prod = fast_a * fast_b;
    end
`endif

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div_i (is_div_q),
        .acc_i    (acc_q),
        .opb_i    (opb_q),
        .acc_o    (acc_step)
    );

    always_comb begin
        is_muldiv_op = (bus.op == OP_MULT) || (bus.op == OP_MULTU) ||
                       (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
        is_div_op    = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
        signed_op    = (bus.op == OP_MULT) || (bus.op == OP_DIV);
        sa           = signed_op & bus.rs_val[XLEN-1];
        sb           = signed_op & bus.rt_val[XLEN-1];
        rs_mag       = sa ? (~bus.rs_val + 1'b1) : bus.rs_val;
        rt_mag       = sb ? (~bus.rt_val + 1'b1) : bus.rt_val;
        // Sign correction applied in FIX; the most-negative / -1 case wraps naturally.
        prod_fix     = (sign_a_q ^ sign_b_q) ? (~acc_q + 1'b1) : acc_q;
        quo_fix      = (sign_a_q ^ sign_b_q) ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
        rem_fix      = sign_a_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        rs_d     = rs_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        is_div_d = is_div_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        done_d   = 1'b0;
        dbz_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (is_muldiv_op) begin
`ifdef MULDIV_FAST_MUL_EN
                        if (!is_div_op) begin
                            {hi_d, lo_d} = fast_prod;
                            done_d       = 1'b1;
                        end else begin
`else
                        begin
`endif
                            is_div_d = is_div_op;
                            sign_a_d = sa;
                            sign_b_d = sb;
                            rs_d     = bus.rs_val;
                            opb_d    = rt_mag;
                            acc_d    = {{XLEN{1'b0}}, rs_mag};
                            cnt_d    = CNT_W'(XLEN);
                            state_d  = ST_RUN;
                        end
                    end else if (bus.op == OP_MTHI) begin
                        hi_d = bus.rs_val;
                    end else if (bus.op == OP_MTLO) begin
                        lo_d = bus.rs_val;
                    end
                end
            end
            ST_RUN: begin
                acc_d = acc_step;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                if (!is_div_q) begin
                    {hi_d, lo_d} = prod_fix;
                end else if (opb_q == '0) begin
                    lo_d  = '1;
                    hi_d  = rs_q;
                    dbz_d = 1'b1;
                end else begin
                    lo_d = quo_fix;
                    hi_d = rem_fix;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            rs_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            rs_q     <= rs_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            is_div_q <= is_div_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed-vector bench for ex_muldiv (XLEN=32) with hand-computed HI/LO results.
module tb_ex_muldiv;
    import muldiv_pkg::*;

    localparam int XLEN = 32;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [63:0] exp_q[$];
    logic [31:0] cur_hi, cur_lo;

    ex_muldiv_if #(.XLEN(XLEN)) bus ();

    ex_muldiv #(.XLEN(XLEN)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a one-cycle request; returns in cycle 1 (one edge after acceptance).
    task automatic issue(input op_t op, input logic [31:0] rs, input logic [31:0] rt);
        bus.start  = 1'b1;
        bus.op     = op;
        bus.rs_val = rs;
        bus.rt_val = rt;
        step();
        bus.start  = 1'b0;
        bus.op     = OP_NOP;
    endtask

    task automatic wait_done(input int c0, output int done_cyc, output int busy_cnt, output int hold_bad);
        int c;
        c        = c0;
        done_cyc = -1;
        busy_cnt = 0;
        hold_bad = 0;
        while (done_cyc < 0 && c < 200) begin
            if (bus.done) begin
                done_cyc = c;
            end else begin
                if (bus.busy) busy_cnt++;
                if (bus.hi !== cur_hi || bus.lo !== cur_lo) hold_bad++;
                step();
                c++;
            end
        end
    endtask

    task automatic run_op(input string tag, input op_t op, input logic [31:0] rs, input logic [31:0] rt,
                          input logic [31:0] ehi, input logic [31:0] elo, input logic edbz);
        int dc, bc, hb, exp_lat, exp_busy;
        logic [63:0] exp_v;
        exp_lat  = XLEN + 2;
        exp_busy = XLEN + 1;
`ifdef MULDIV_FAST_MUL_EN
        if (op == OP_MULT || op == OP_MULTU) begin
            exp_lat  = 1;
            exp_busy = 0;
        end
`endif
        exp_q.push_back({ehi, elo});
        issue(op, rs, rt);
        wait_done(1, dc, bc, hb);
        exp_v = exp_q.pop_front();
        check({tag, "_done_cycle"}, 64'(dc), 64'(exp_lat));
        check({tag, "_busy_cycles"}, 64'(bc), 64'(exp_busy));
        check({tag, "_hold"}, 64'(hb), 64'd0);
        check({tag, "_hi"}, 64'(bus.hi), 64'(exp_v[63:32]));
        check({tag, "_lo"}, 64'(bus.lo), 64'(exp_v[31:0]));
        check({tag, "_dbz"}, 64'(bus.div_by_zero), 64'(edbz));
        cur_hi = exp_v[63:32];
        cur_lo = exp_v[31:0];
    endtask

    task automatic check_pulse_end(input string tag);
        step();
        check({tag, "_done_clear"}, 64'(bus.done), 64'd0);
        check({tag, "_dbz_clear"}, 64'(bus.div_by_zero), 64'd0);
    endtask

    initial begin
        int dc, bc, hb, busy_seen, done_seen;
        op_t first_op, second_op;
        logic [31:0] f_rs, f_rt, f_hi, f_lo;

        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.op     = OP_NOP;
        bus.rs_val = '0;
        bus.rt_val = '0;
        cur_hi     = '0;
        cur_lo     = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_dbz", 64'(bus.div_by_zero), 64'd0);
        check("rst_hi", 64'(bus.hi), 64'd0);
        check("rst_lo", 64'(bus.lo), 64'd0);
        check("rst_state", 64'(bus.dbg_state), 64'(ST_IDLE));

        run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
        check_pulse_end("multu");
        run_op("mult", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        check_pulse_end("mult");
        run_op("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        check_pulse_end("div");
        run_op("divu_zero", OP_DIVU, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1);
        check_pulse_end("divu_zero");
        run_op("div_zero_neg", OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
        // Next op issued in the done cycle itself: back-to-back acceptance.
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
        run_op("divu", OP_DIVU, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E, 1'b0);
        check_pulse_end("divu");
        run_op("mult_negneg", OP_MULT, 32'hFFFF_FFFC, 32'hFFFF_FFFA, 32'h0000_0000, 32'h0000_0018, 1'b0);
        check_pulse_end("mult_negneg");
        run_op("div_negneg", OP_DIV, 32'hFFFF_FFF1, 32'hFFFF_FFFC, 32'hFFFF_FFFD, 32'h0000_0003, 1'b0);
        check_pulse_end("div_negneg");

        // MTHI then MTLO back to back in IDLE.
        bus.start  = 1'b1;
        bus.op     = OP_MTHI;
        bus.rs_val = 32'h1234_5678;
        step();
        check("mthi_hi", 64'(bus.hi), 64'h1234_5678);
        check("mthi_lo", 64'(bus.lo), 64'(cur_lo));
        check("mthi_done", 64'(bus.done), 64'd0);
        bus.op     = OP_MTLO;
        bus.rs_val = 32'hCAFE_BABE;
        step();
        bus.start  = 1'b0;
        bus.op     = OP_NOP;
        check("mtlo_lo", 64'(bus.lo), 64'hCAFE_BABE);
        check("mtlo_hi", 64'(bus.hi), 64'h1234_5678);
        check("mtlo_done", 64'(bus.done), 64'd0);
        check("mtlo_busy", 64'(bus.busy), 64'd0);
        cur_hi = 32'h1234_5678;
        cur_lo = 32'hCAFE_BABE;

        // Reserved op code must leave HI/LO alone.
        bus.start  = 1'b1;
        bus.op     = OP_RSVD;
        bus.rs_val = 32'h5555_AAAA;
        step();
        bus.start  = 1'b0;
        bus.op     = OP_NOP;
        check("rsvd_hi", 64'(bus.hi), 64'(cur_hi));
        check("rsvd_busy", 64'(bus.busy), 64'd0);

        // Second start while busy is dropped.
`ifdef MULDIV_FAST_MUL_EN
        first_op  = OP_DIVU;
        f_rs      = 32'h002D_C6C0;
        f_rt      = 32'd1000;
        f_hi      = 32'h0000_0000;
        f_lo      = 32'h0000_0BB8;
        second_op = OP_MULTU;
`else
        first_op  = OP_MULTU;
        f_rs      = 32'd1000;
        f_rt      = 32'd3000;
        f_hi      = 32'h0000_0000;
        f_lo      = 32'h002D_C6C0;
        second_op = OP_DIVU;
`endif
        exp_q.push_back({f_hi, f_lo});
        issue(first_op, f_rs, f_rt);
        repeat (3) step();
        bus.start  = 1'b1;
        bus.op     = second_op;
        bus.rs_val = 32'd9;
        bus.rt_val = 32'd3;
        step();
        bus.start  = 1'b0;
        bus.op     = OP_NOP;
        wait_done(5, dc, bc, hb);
        begin
            logic [63:0] exp_v;
            exp_v = exp_q.pop_front();
            check("ign_done_cycle", 64'(dc), 64'(XLEN + 2));
            check("ign_hold", 64'(hb), 64'd0);
            check("ign_hi", 64'(bus.hi), 64'(exp_v[63:32]));
            check("ign_lo", 64'(bus.lo), 64'(exp_v[31:0]));
        end
        busy_seen = 0;
        repeat (4) begin
            step();
            if (bus.busy || bus.done) busy_seen++;
        end
        check("ign_no_queue", 64'(busy_seen), 64'd0);

        // Reset in the middle of a DIV.
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        repeat (8) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_hi", 64'(bus.hi), 64'd0);
        check("midrst_lo", 64'(bus.lo), 64'd0);
        done_seen = 0;
        repeat (40) begin
            if (bus.done || bus.busy) done_seen++;
            step();
        end
        check("midrst_no_done", 64'(done_seen), 64'd0);
        check("midrst_lo_after", 64'(bus.lo), 64'd0);
        cur_hi = '0;
        cur_lo = '0;

`ifdef MULDIV_FAST_MUL_EN
        run_op("fast_mult", OP_MULT, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF2, 1'b0);
        check_pulse_end("fast_mult");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
